// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU instruction/data memory arbiter.
// Imported by the pick sub-module and the arbiter top.
package mem_arb_pkg;

    typedef enum logic { IDLE, WAIT } arb_state_e;
    typedef enum logic { OWN_INST, OWN_DATA } owner_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way pick between instruction and data requesters.
// On a conflict the master that did not win last time is chosen.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   inst_req,
    input  logic   data_req,
    input  owner_e last_grant,
    output logic   grant_data
);

    assign grant_data = data_req & (~inst_req | (last_grant == OWN_INST));

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Muxes CPU instruction and data request ports onto one shared memory port,
// with a single outstanding transaction and alternating grants on conflict.
module cpu_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    output logic                mem_req,
    output logic                mem_wr,
    output logic [1:0]          mem_size,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_e state, state_nxt;
    owner_e     owner, owner_nxt;
    owner_e     last_grant, last_grant_nxt;
    logic       grant_data;
    logic       accept;
    logic       resp;

    mem_arb_pick u_pick (
        .inst_req   (inst_req),
        .data_req   (data_req),
        .last_grant (last_grant),
        .grant_data (grant_data)
    );

    // Request mux: only the winner is presented, and only while IDLE.
    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = '0;
        mem_wstrb = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == IDLE) begin
            if (grant_data) begin
                mem_req   = 1'b1;
                mem_wr    = data_wr;
                mem_size  = data_size;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else if (inst_req) begin
                mem_req   = 1'b1;
                mem_size  = SZ_WORD;
                mem_addr  = inst_addr;
            end
        end
        if (rst) mem_req = 1'b0;
    end

    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & ~grant_data;
    assign data_addr_ok = accept &  grant_data;

    // A response only counts while a transaction is outstanding.
    assign resp         = ~rst & (state == WAIT) & mem_data_ok;
    assign inst_data_ok = resp & (owner == OWN_INST);
    assign data_data_ok = resp & (owner == OWN_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: if (accept) begin
                state_nxt      = WAIT;
                owner_nxt      = grant_data ? OWN_DATA : OWN_INST;
                last_grant_nxt = grant_data ? OWN_DATA : OWN_INST;
            end
            WAIT: if (mem_data_ok) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_INST;
            last_grant <= OWN_INST;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: reset, single reads, alternation,
// byte write, withdrawal, reset mid-transaction and a stalled memory.
module tb_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    // {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req}
    logic [4:0] hs;
    assign hs = {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req};

    always #5 clk = ~clk;

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    // Advance one cycle; inputs are then changed 1 time unit after the edge
    // and outputs sampled a further unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_addr = '0;
        data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0;
        data_addr = '0; data_wdata = '0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        #1;
        checks++;
        if (hs !== 5'b00000) begin
            errors++; $display("FAIL reset_forced hs=%b expected=%b", hs, 5'b00000);
        end
        tick(); tick();
        rst = 0;
        clear_inputs();
        #1;
        checks++;
        if (hs !== 5'b00000 || mem_addr !== 32'h0 || mem_size !== 2'd0) begin
            errors++; $display("FAIL idle_outputs hs=%b addr=%h size=%0d expected 0", hs, mem_addr, mem_size);
        end
        tick();
        mem_data_ok = 1; mem_rdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (hs !== 5'b00000) begin
            errors++; $display("FAIL stray_data_ok hs=%b expected=%b", hs, 5'b00000);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_inst_read();
        inst_req = 1; inst_addr = 32'hBFC00000; mem_addr_ok = 1;
        #1;
        checks++;
        if (hs !== 5'b10001 || mem_addr !== 32'hBFC00000 || mem_wr !== 0 || mem_size !== 2'd2 || mem_wstrb !== 4'h0) begin
            errors++; $display("FAIL inst_accept hs=%b addr=%h wr=%b size=%0d expected hs=10001 addr=bfc00000 wr=0 size=2", hs, mem_addr, mem_wr, mem_size);
        end
        tick();
        inst_req = 0; mem_addr_ok = 0;
        for (int t = 1; t <= 2; t++) begin
            #1;
            checks++;
            if (hs !== 5'b00000) begin
                errors++; $display("FAIL inst_wait_T%0d hs=%b expected=00000", t, hs);
            end
            tick();
        end
        mem_data_ok = 1; mem_rdata = 32'h24080001;
        #1;
        checks++;
        if (hs !== 5'b00100 || inst_rdata !== 32'h24080001) begin
            errors++; $display("FAIL inst_resp hs=%b rdata=%h expected hs=00100 rdata=24080001", hs, inst_rdata);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_alternate();
        logic [4:0] exp_acc, exp_resp;
        logic       dwin;
        inst_req = 1; inst_addr = 32'hBFC00004;
        data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80000010;
        for (int k = 0; k < 3; k++) begin
            dwin = (k % 2 == 0);
            exp_acc  = dwin ? 5'b01001 : 5'b10001;
            exp_resp = dwin ? 5'b00010 : 5'b00100;
            mem_addr_ok = 1; mem_data_ok = 0;
            #1;
            checks++;
            if (hs !== exp_acc || mem_addr !== (dwin ? 32'h80000010 : 32'hBFC00004) || mem_wr !== 0) begin
                errors++; $display("FAIL alt_grant%0d hs=%b addr=%h wr=%b expected hs=%b", k, hs, mem_addr, mem_wr, exp_acc);
            end
            tick();
            // Both requests remain raised during WAIT; nothing may be issued.
            mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h100 + k;
            #1;
            checks++;
            if (hs !== exp_resp) begin
                errors++; $display("FAIL alt_resp%0d hs=%b expected=%b", k, hs, exp_resp);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_byte_write();
        data_req = 1; data_wr = 1; data_size = 0; data_wstrb = 4'h2;
        data_addr = 32'h80000001; data_wdata = 32'h0000AB00; mem_addr_ok = 1;
        #1;
        checks++;
        if (hs !== 5'b01001 || mem_wr !== 1 || mem_size !== 2'd0 || mem_wstrb !== 4'h2 ||
            mem_addr !== 32'h80000001 || mem_wdata !== 32'h0000AB00) begin
            errors++; $display("FAIL wr_fields hs=%b wr=%b size=%0d strb=%h addr=%h wdata=%h expected 01001 1 0 2 80000001 0000ab00",
                               hs, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata);
        end
        tick();
        data_req = 0; mem_addr_ok = 0;
        #1;
        checks++;
        if (hs !== 5'b00000) begin
            errors++; $display("FAIL wr_wait hs=%b expected=00000", hs);
        end
        tick();
        mem_data_ok = 1;
        #1;
        checks++;
        if (hs !== 5'b00010) begin
            errors++; $display("FAIL wr_done hs=%b expected=00010", hs);
        end
        tick();
        clear_inputs();
        // Withdrawal: request without acceptance, then drop it.
        data_req = 1; data_addr = 32'h80000040;
        #1;
        checks++;
        if (hs !== 5'b00001 || mem_addr !== 32'h80000040) begin
            errors++; $display("FAIL withdraw_pending hs=%b addr=%h expected 00001 80000040", hs, mem_addr);
        end
        tick();
        data_req = 0;
        #1;
        checks++;
        if (hs !== 5'b00000) begin
            errors++; $display("FAIL withdraw_gone hs=%b expected=00000", hs);
        end
        tick();
        // Still IDLE: an inst request is accepted immediately.
        inst_req = 1; inst_addr = 32'hBFC00008; mem_addr_ok = 1;
        #1;
        checks++;
        if (hs !== 5'b10001) begin
            errors++; $display("FAIL withdraw_idle hs=%b expected=10001", hs);
        end
        tick();
        clear_inputs();
        mem_data_ok = 1;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_in_wait();
        // Data transaction leaves last_grant=DATA and the arbiter in WAIT.
        data_req = 1; data_addr = 32'h80000020; data_size = 2; mem_addr_ok = 1;
        #1;
        checks++;
        if (hs !== 5'b01001) begin
            errors++; $display("FAIL rw_accept hs=%b expected=01001", hs);
        end
        tick();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; rst = 1;
        #1;
        checks++;
        if (hs !== 5'b00000) begin
            errors++; $display("FAIL rw_forced hs=%b expected=00000", hs);
        end
        tick();
        rst = 0;
        // Late response plus a conflict: IDLE ignores it, data wins (last_grant=INST).
        inst_req = 1; inst_addr = 32'hBFC0000C; data_req = 1; mem_data_ok = 1;
        #1;
        checks++;
        if (hs !== 5'b00001 || mem_addr !== 32'h80000020) begin
            errors++; $display("FAIL rw_after hs=%b addr=%h expected 00001 80000020", hs, mem_addr);
        end
        tick();
        inst_req = 0; mem_data_ok = 0; mem_addr_ok = 1;
        #1;
        checks++;
        if (hs !== 5'b01001) begin
            errors++; $display("FAIL rw_new_accept hs=%b expected=01001", hs);
        end
        tick();
        clear_inputs();
        mem_data_ok = 1;
        #1;
        checks++;
        if (hs !== 5'b00010) begin
            errors++; $display("FAIL rw_new_resp hs=%b expected=00010", hs);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_stall();
        // last_grant is DATA, so inst wins this conflict.
        inst_req = 1; inst_addr = 32'hBFC00010;
        data_req = 1; data_wr = 1; data_size = 1; data_wstrb = 4'h3;
        data_addr = 32'h80000030; data_wdata = 32'h1234;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (hs !== 5'b00001 || mem_addr !== 32'hBFC00010 || mem_wr !== 0 ||
                mem_size !== 2'd2 || mem_wstrb !== 4'h0 || mem_wdata !== 32'h0) begin
                errors++; $display("FAIL stall_c%0d hs=%b addr=%h wr=%b size=%0d expected 00001 bfc00010 0 2", c, hs, mem_addr, mem_wr, mem_size);
            end
            tick();
        end
        // Accept with a simultaneous (stray) data_ok.
        mem_addr_ok = 1; mem_data_ok = 1;
        #1;
        checks++;
        if (hs !== 5'b10001) begin
            errors++; $display("FAIL stall_accept hs=%b expected=10001", hs);
        end
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hCAFE0001;
        #1;
        checks++;
        if (hs !== 5'b00100 || inst_rdata !== 32'hCAFE0001) begin
            errors++; $display("FAIL stall_resp hs=%b rdata=%h expected 00100 cafe0001", hs, inst_rdata);
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        tick();
        test_reset();
        test_inst_read();
        test_alternate();
        test_byte_write();
        test_reset_in_wait();
        test_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Arbitrates the CPU core's instruction and data SRAM-like request ports onto a single shared memory port, and tracks one outstanding transaction at a time. Sits directly downstream of the CPU top. It replaces the core's fixed-latency SRAM assumption with a req/addr_ok/data_ok handshake toward a variable-latency memory or bus bridge. Data requests have priority; a 2-way fairness rule prevents instruction-fetch starvation.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (wstrb width = DATA_W/8)
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, synchronous and active-high
- inst_req  in  1  instruction read request
- inst_addr  in  ADDR_W  instruction byte address
- inst_addr_ok  out  1  request accepted this cycle
- inst_data_ok  out  1  read data valid this cycle
- inst_rdata  out  DATA_W  read data
- data_req  in  1  data request
- data_wr  in  1  1 = write, 0 = read
- data_size  in  2  0 byte, 1 half, 2 word
- data_wstrb  in  DATA_W/8  byte enables (writes)
- data_addr  in  ADDR_W  data byte address
- data_wdata  in  DATA_W  write data
- data_addr_ok  out  1  request accepted this cycle
- data_data_ok  out  1  read data valid / write complete
- data_rdata  out  DATA_W  read data
- mem_req  out  1  shared-port request
- mem_wr  out  1  write
- mem_size  out  2  size
- mem_wstrb  out  DATA_W/8  byte enables
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_addr_ok  in  1  memory accepted request
- mem_data_ok  in  1  memory response
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, WAIT. Registers: state, owner (INST/DATA), last_grant (INST/DATA).
- IDLE, arbitration (combinational): only one requester wins it. On conflict, the winner is the master that is not last_grant. last_grant resets to INST, so data wins the first conflict.
- IDLE: mem_* is driven from the winner and mem_req = winner's req.
  - Inst fields: mem_wr=0, mem_size=2, mem_wstrb=0, mem_wdata=0.
  - With no requester: mem_req=0 and the other mem_* outputs are 0.
- Accept: mem_req & mem_addr_ok in IDLE produces the following.
  - Winner's *_addr_ok=1 in the same cycle.
  - Next cycle: state=WAIT, owner=winner, last_grant=winner.
- WAIT: mem_req=0. Both *_addr_ok=0. New requests are held off.
- mem_data_ok in WAIT asserts owner's *_data_ok the same cycle. The next state is IDLE.
- *_rdata = mem_rdata pass-through to both masters. The value is meaningful only when that master's data_ok=1.
- Writes complete via data_data_ok; data_rdata is don't-care then.
- mem_data_ok in IDLE (stray) is ignored: no *_data_ok is raised.
- Masters hold req and all request fields stable until addr_ok. The arbiter does not re-check this.
- A master that deasserts req before acceptance withdraws cleanly; no state change.

## Timing
- Reset (rst=1 at an edge): state=IDLE, last_grant=INST.
- While rst=1, mem_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok are forced to 0.
- Reset mid-WAIT abandons the outstanding transaction. The memory side shares rst and must drop it too. A late mem_data_ok after reset is ignored per the IDLE rule.
- Accept latency: 0 cycles (addr_ok is combinational from mem_addr_ok).
- Response latency: data_ok is combinational from mem_data_ok.
- Minimum turnaround: the earliest next acceptance is the cycle after data_ok. There is one IDLE cycle between back-to-back transactions, so peak throughput is 1 per (2 + memory latency) cycles.
- mem_addr_ok and mem_data_ok in the same cycle while IDLE: accept only. The data_ok is treated as stray.
- Only one transaction is outstanding system-wide; there is no buffering.

## Structure
- Shared package mem_arb_pkg:
  - state enum {IDLE, WAIT}
  - owner enum {OWN_INST, OWN_DATA}
  - size constants SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2
- Sub-module mem_arb_pick: combinational 2-way priority/round-robin pick.
  - Inputs: inst_req, data_req, last_grant.
  - Output: grant_data.
- Everything else lives in cpu_mem_arbiter.

## Test plan
- Reset, then idle: all handshake outputs 0. A stray mem_data_ok with rdata=0xDEADBEEF raises no data_ok.
- Single inst read at 0xBFC00000, mem_addr_ok in the same cycle, data_ok 3 cycles later with 0x24080001:
  - inst_addr_ok at T0; inst_data_ok and inst_rdata=0x24080001 at T3.
  - mem_req=0 during T1–T3.
- Simultaneous inst_req and data_req (read 0x80000010) held continuously:
  - Grants alternate: data, inst, data.
  - Each grant sees mem_addr matching its master and mem_wr=0 for inst.
- Data byte write (size 0, wstrb 0x2, addr 0x80000001, wdata 0x0000AB00):
  - mem_* fields pass through exactly.
  - data_data_ok follows mem_data_ok.
  - Then data_req withdrawn before addr_ok: no grant, state stays IDLE.
- rst asserted in WAIT:
  - Next cycle IDLE with last_grant=INST.
  - A following mem_data_ok is ignored.
  - A new data_req is accepted normally.
- Stalled memory (mem_addr_ok=0 for 5 cycles) with inst_req and data_req both held: the winner's fields stay stable on mem_*, and no addr_ok is raised until mem_addr_ok.
